approx_add_pipe: RTL and testbench
==================================

# approx_add_pipe

Parametrised, pipelined approximate adder with a runtime-selectable approximation mode and built-in error statistics. It generalises the fixed 8-bit lower-part approximate adders to any operand width and approximation depth. Operands move through an elastic valid/ready pipeline. Each result is checked against the exact sum so that accuracy (error rate, mean error, worst-case error) can be measured in-system.

## Interface
- `WIDTH`, 8: operand width in bits (2..32).
- `APPROX_BITS`, 4: number of low bits subject to approximation (0..WIDTH).
- `STAGES`, 2: pipeline register stages (1..4); latency in cycles.
- `ACC_W`, 32: width of statistic counters.

Ports:
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: pipeline accepts a beat.
- `in_a`, `in_b`  in  WIDTH: operands, unsigned.
- `in_mode`  in  2: approximation mode for this beat.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_sum`  out  WIDTH+1: approximate sum.
- `out_err`  out  WIDTH+1: |out_sum − exact sum| for this beat.
- `stat_clr`  in  1: synchronous clear of all statistics.
- `stat_samples`  out  ACC_W: handshaken results since clear.
- `stat_err_cnt`  out  ACC_W: results with nonzero error.
- `stat_err_sum`  out  ACC_W: accumulated absolute error.
- `stat_err_max`  out  WIDTH+1: largest error seen.

## Operation
- Let K = APPROX_BITS, L = low K bits, H = upper WIDTH−K bits. Only L is approximated; H is always an exact adder with carry-in c and carry-out to bit WIDTH.
- Mode 0, EXACT: full exact add.
- Mode 1, LOA: L = a_L | b_L; c = a[K−1] & b[K−1] (c = 0 if K = 0).
- Mode 2, TRUNC: L = 0; c = 0.
- Mode 3, SETONE: L = all ones; c = 0.
- If K = 0, all modes equal EXACT. If K = WIDTH, H is empty and out_sum[WIDTH] = c.
- The mode is captured with the operands and travels with the beat. A mode change takes effect per beat, with no flush.
- The exact sum and out_err are computed in the same pipeline as the approximate sum.
- Statistics update only on an output handshake (out_valid & out_ready):
  - samples += 1
  - err_cnt += (err ≠ 0)
  - err_sum += err
  - err_max = max(err_max, err)
- All counters saturate at all-ones and never wrap.
- stat_clr zeroes the statistics next cycle. If it coincides with a handshake, clear wins and that sample is not counted. stat_clr does not affect the data pipeline.

## Timing
- Latency is exactly STAGES cycles from input handshake to out_valid when out_ready is held high. Throughput is 1 beat per cycle.
- Elastic per stage: a stage loads when it is empty or its content is advancing. in_ready = stage0 empty or stage0 advancing. in_ready never depends on in_valid.
- With out_ready low, the pipeline fills. in_ready falls after STAGES beats are accepted. No beat is lost or reordered.
- out_sum, out_err and out_valid come directly from registers. They are held stable while out_valid & !out_ready.
- Reset: all stage valids are 0; out_valid = 0; out_sum, out_err and all stat outputs are 0. in_ready = 1 from the first cycle after reset.
- Reset asserted mid-operation drops every in-flight beat. Statistics do not count them.

## Structure
- Package `approx_add_pkg`:
  - mode enum `approx_mode_e` (EXACT, LOA, TRUNC, SETONE).
  - pure function `approx_sum(a, b, mode, K)` returning WIDTH+1 bits, shared with the bench reference model.
- Sub-module `approx_err_stats`: the saturating counters and max tracker, fed by the handshake strobe and err.
- Top level: the pipeline registers, the datapath function, and the handshake logic.

## Test plan
All scenarios use WIDTH=8, APPROX_BITS=4, STAGES=2 unless noted.
- LOA, a=0x3C, b=0x25 → out_sum=0x05D, out_err=4, exactly 2 cycles after accept.
- EXACT, a=0xFF, b=0x01 → out_sum=0x100, out_err=0. TRUNC, 0x0F+0x0F → out_sum=0x000, out_err=30. SETONE, 0x00+0x00 → out_sum=0x00F, out_err=15.
- After the four beats above: stat_samples=4, stat_err_cnt=3, stat_err_sum=49, stat_err_max=30.
- stat_clr pulsed in the same cycle as the next handshake → all stats 0 the following cycle.
- Back-to-back stream of 10 random beats with out_ready low for cycles 3–7:
  - in_ready low after 2 held beats.
  - All 10 results appear in order and match `approx_sum`.
- rst for 1 cycle with 2 beats in flight → out_valid=0, stats=0 next cycle. Neither beat ever appears.
- APPROX_BITS=0 build, random modes → out_err always 0.

Source files
------------

// File: rtl/approx_add_pipe_pkg.sv
// approx_add_pkg: approximation modes and the shared approximate-sum function
package approx_add_pkg;
  typedef enum logic [1:0] {EXACT, LOA, TRUNC, SETONE} approx_mode_e;
  function automatic logic [32:0] approx_sum(input logic [31:0] a, input logic [31:0] b,
                                             input approx_mode_e mode, input int k);
    logic [32:0] aa, bb, mask, top, lo, hi;
    logic c;
    aa = {1'b0, a};
    bb = {1'b0, b};
    mask = (33'd1 << k) - 33'd1;
    top = k == 0 ? '0 : 33'd1 << (k - 1);
    c = mode == LOA && |(aa & bb & top);
    lo = mode == LOA ? (aa | bb) & mask : mode == SETONE ? mask : '0;
    hi = ((aa >> k) + (bb >> k) + {32'd0, c}) << k;
    return mode == EXACT || k == 0 ? aa + bb : hi | lo;
  endfunction
endpackage

// File: rtl/approx_add_pipe_if.sv
// approx_add_pipe_if: operand/result handshake and statistics bundle
interface approx_add_pipe_if #(parameter int WIDTH = 8, parameter int ACC_W = 32);
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [1:0]       in_mode;
  logic             out_valid, out_ready;
  logic [WIDTH:0]   out_sum, out_err;
  logic             stat_clr;
  logic [ACC_W-1:0] stat_samples, stat_err_cnt, stat_err_sum;
  logic [WIDTH:0]   stat_err_max;
  modport master (output in_valid, in_a, in_b, in_mode, out_ready, stat_clr,
                  input in_ready, out_valid, out_sum, out_err,
                  stat_samples, stat_err_cnt, stat_err_sum, stat_err_max);
  modport slave (input in_valid, in_a, in_b, in_mode, out_ready, stat_clr,
                 output in_ready, out_valid, out_sum, out_err,
                 stat_samples, stat_err_cnt, stat_err_sum, stat_err_max);
endinterface

// File: rtl/approx_err_stats.sv
// approx_err_stats: saturating sample/error counters and worst-case error tracker
module approx_err_stats #(
  parameter int ACC_W = 32,
  parameter int EW = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hs,
  input  logic [EW-1:0]    err,
  output logic [ACC_W-1:0] samples,
  output logic [ACC_W-1:0] err_cnt,
  output logic [ACC_W-1:0] err_sum,
  output logic [EW-1:0]    err_max
);
  localparam int SW = (ACC_W > EW ? ACC_W : EW) + 1;
  localparam logic [ACC_W-1:0] SAT = '1;
  logic [ACC_W-1:0] samples_q, samples_d, cnt_q, cnt_d, sum_q, sum_d;
  logic [EW-1:0] max_q, max_d;
  logic [SW-1:0] sum_w;
  always_comb begin
    sum_w = SW'(sum_q) + SW'(err);
    samples_d = clr ? '0 : hs && samples_q != SAT ? samples_q + ACC_W'(1) : samples_q;
    cnt_d = clr ? '0 : hs && err != '0 && cnt_q != SAT ? cnt_q + ACC_W'(1) : cnt_q;
    sum_d = clr ? '0 : !hs ? sum_q : sum_w > SW'(SAT) ? SAT : sum_w[ACC_W-1:0];
    max_d = clr ? '0 : hs && err > max_q ? err : max_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      samples_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else begin
      samples_q <= samples_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      max_q <= max_d;
    end
  end
  assign samples = samples_q;
  assign err_cnt = cnt_q;
  assign err_sum = sum_q;
  assign err_max = max_q;
endmodule

// File: rtl/approx_add_pipe.sv
// approx_add_pipe: elastic pipelined approximate adder with per-beat mode and error statistics
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int APPROX_BITS = 4,
  parameter int STAGES = 2,
  parameter int ACC_W = 32
) (
  input logic clk,
  input logic rst,
  approx_add_pipe_if.slave io
);
  localparam int EW = WIDTH + 1;
  logic [STAGES-1:0] v_q, v_d, rdy;
  logic [EW-1:0] sum_q [STAGES];
  logic [EW-1:0] sum_d [STAGES];
  logic [EW-1:0] err_q [STAGES];
  logic [EW-1:0] err_d [STAGES];
  logic [EW-1:0] a_sum, x_sum, a_err;
  logic full;
  always_comb begin
    a_sum = EW'(approx_sum(32'(io.in_a), 32'(io.in_b), approx_mode_e'(io.in_mode), APPROX_BITS));
    x_sum = EW'(approx_sum(32'(io.in_a), 32'(io.in_b), EXACT, 0));
    a_err = a_sum >= x_sum ? a_sum - x_sum : x_sum - a_sum;
  end
  // a stage may load unless it and every stage after it are full and the output is stalled
  always_comb begin
    full = 1'b1;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full = full & v_q[i];
      rdy[i] = io.out_ready | ~full;
    end
  end
  always_comb begin
    v_d[0] = rdy[0] ? io.in_valid : v_q[0];
    sum_d[0] = rdy[0] ? a_sum : sum_q[0];
    err_d[0] = rdy[0] ? a_err : err_q[0];
    for (int i = 1; i < STAGES; i++) begin
      v_d[i] = rdy[i] ? v_q[i-1] : v_q[i];
      sum_d[i] = rdy[i] ? sum_q[i-1] : sum_q[i];
      err_d[i] = rdy[i] ? err_q[i-1] : err_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        sum_q[i] <= '0;
        err_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
  assign io.in_ready = rdy[0];
  assign io.out_valid = v_q[STAGES-1];
  assign io.out_sum = sum_q[STAGES-1];
  assign io.out_err = err_q[STAGES-1];
  approx_err_stats #(.ACC_W(ACC_W), .EW(EW)) u_stats (
    .clk(clk),
    .rst(rst),
    .clr(io.stat_clr),
    .hs(io.out_valid & io.out_ready),
    .err(io.out_err),
    .samples(io.stat_samples),
    .err_cnt(io.stat_err_cnt),
    .err_sum(io.stat_err_sum),
    .err_max(io.stat_err_max)
  );
endmodule

// File: tb/tb_approx_add_pipe.sv
// tb_approx_add_pipe: randomized and directed checks of approx_add_pipe against an arithmetic model
module tb_approx_add_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int got_s[$];
  int got_e[$];
  always #5 clk = ~clk;
  approx_add_pipe_if #(.WIDTH(8), .ACC_W(32)) io ();
  approx_add_pipe_if #(.WIDTH(8), .ACC_W(32)) io0 ();
  approx_add_pipe #(.WIDTH(8), .APPROX_BITS(4), .STAGES(2), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .io(io.slave));
  approx_add_pipe #(.WIDTH(8), .APPROX_BITS(0), .STAGES(2), .ACC_W(32)) dut0 (
    .clk(clk), .rst(rst), .io(io0.slave));

  always @(negedge clk)
    if (!rst && io.out_valid && io.out_ready) begin
      got_s.push_back(int'(io.out_sum));
      got_e.push_back(int'(io.out_err));
    end

  function automatic int ref_sum(input int a, input int b, input int m, input int k);
    int p, al, bl, lo, c;
    p = 1 << k;
    al = a % p;
    bl = b % p;
    if (m == 0 || k == 0) return a + b;
    c = (m == 1 && al >= p / 2 && bl >= p / 2) ? 1 : 0;
    lo = m == 1 ? (al | bl) : m == 3 ? p - 1 : 0;
    return (a / p + b / p + c) * p + lo;
  endfunction

  function automatic int ref_err(input int a, input int b, input int m, input int k);
    int d;
    d = ref_sum(a, b, m, k) - (a + b);
    return d < 0 ? -d : d;
  endfunction

  task automatic send(input int a, input int b, input int m);
    io.in_valid = 1'b1;
    io.in_a = 8'(a);
    io.in_b = 8'(b);
    io.in_mode = 2'(m);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (io.in_ready) begin
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL send_timeout in_ready stayed 0 for 50 cycles");
    io.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    io.in_valid = 0; io.in_a = 0; io.in_b = 0; io.in_mode = 0; io.out_ready = 1; io.stat_clr = 0;
    io0.in_valid = 0; io0.in_a = 0; io0.in_b = 0; io0.in_mode = 0; io0.out_ready = 1; io0.stat_clr = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", io.out_valid); end
    checks++; if (io.out_sum !== 9'd0) begin failures++; $display("FAIL reset_out_sum got=%0d exp=0", io.out_sum); end
    checks++; if (io.out_err !== 9'd0) begin failures++; $display("FAIL reset_out_err got=%0d exp=0", io.out_err); end
    checks++; if (io.stat_samples !== 32'd0 || io.stat_err_cnt !== 32'd0 || io.stat_err_sum !== 32'd0 || io.stat_err_max !== 9'd0) begin
      failures++; $display("FAIL reset_stats got=%0d/%0d/%0d/%0d exp=0/0/0/0", io.stat_samples, io.stat_err_cnt, io.stat_err_sum, io.stat_err_max);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int es[4] = '{'h5D, 'h100, 0, 'h0F};
    int ee[4] = '{4, 0, 30, 15};
    got_s.delete(); got_e.delete();
    io.out_ready = 1;
    io.in_valid = 1; io.in_a = 8'h3C; io.in_b = 8'h25; io.in_mode = 2'd1;
    @(negedge clk);
    checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL loa_accept in_ready got=%b exp=1", io.in_ready); end
    @(posedge clk); #1;
    io.in_valid = 0;
    @(negedge clk);
    checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL loa_latency1 out_valid got=%b exp=0", io.out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (io.out_valid !== 1'b1) begin failures++; $display("FAIL loa_latency2 out_valid got=%b exp=1", io.out_valid); end
    checks++; if (io.out_sum !== 9'h05D) begin failures++; $display("FAIL loa_sum got=%h exp=05d", io.out_sum); end
    checks++; if (io.out_err !== 9'd4) begin failures++; $display("FAIL loa_err got=%0d exp=4", io.out_err); end
    @(posedge clk); #1;
    send('hFF, 'h01, 0);
    send('h0F, 'h0F, 2);
    send('h00, 'h00, 3);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (got_s.size() != 4) begin failures++; $display("FAIL directed_count got=%0d exp=4", got_s.size()); end
    for (int i = 0; i < 4 && i < got_s.size(); i++) begin
      checks++; if (got_s[i] !== es[i] || got_e[i] !== ee[i]) begin
        failures++; $display("FAIL directed_beat%0d got=%h/%0d exp=%h/%0d", i, got_s[i], got_e[i], es[i], ee[i]);
      end
    end
    @(negedge clk);
    checks++; if (io.stat_samples !== 32'd4) begin failures++; $display("FAIL stat_samples got=%0d exp=4", io.stat_samples); end
    checks++; if (io.stat_err_cnt !== 32'd3) begin failures++; $display("FAIL stat_err_cnt got=%0d exp=3", io.stat_err_cnt); end
    checks++; if (io.stat_err_sum !== 32'd49) begin failures++; $display("FAIL stat_err_sum got=%0d exp=49", io.stat_err_sum); end
    checks++; if (io.stat_err_max !== 9'd30) begin failures++; $display("FAIL stat_err_max got=%0d exp=30", io.stat_err_max); end
    @(posedge clk); #1;
  endtask

  task automatic test_clr();
    send('h12, 'h34, 1);
    @(posedge clk); #1;
    io.stat_clr = 1;
    @(negedge clk);
    checks++; if ((io.out_valid & io.out_ready) !== 1'b1) begin failures++; $display("FAIL clr_handshake got=%b exp=1", io.out_valid & io.out_ready); end
    @(posedge clk); #1;
    io.stat_clr = 0;
    @(negedge clk);
    checks++; if (io.stat_samples !== 32'd0 || io.stat_err_cnt !== 32'd0 || io.stat_err_sum !== 32'd0 || io.stat_err_max !== 9'd0) begin
      failures++; $display("FAIL clr_stats got=%0d/%0d/%0d/%0d exp=0/0/0/0", io.stat_samples, io.stat_err_cnt, io.stat_err_sum, io.stat_err_max);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int ba[10], bb[10], bm[10];
    int idx;
    logic acc;
    for (int i = 0; i < 10; i++) begin
      ba[i] = $urandom_range(0, 255); bb[i] = $urandom_range(0, 255); bm[i] = $urandom_range(0, 3);
    end
    got_s.delete(); got_e.delete();
    idx = 0;
    for (int cyc = 0; cyc < 100 && idx < 10; cyc++) begin
      io.out_ready = !(cyc >= 3 && cyc <= 7);
      io.in_valid = 1;
      io.in_a = 8'(ba[idx]); io.in_b = 8'(bb[idx]); io.in_mode = 2'(bm[idx]);
      @(negedge clk);
      if (cyc == 5) begin
        checks++; if (io.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_held got=%b exp=0", io.in_ready); end
        checks++; if (io.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_out_valid_held got=%b exp=1", io.out_valid); end
        checks++; if (io.out_sum !== 9'(ref_sum(ba[1], bb[1], bm[1], 4))) begin
          failures++; $display("FAIL b2b_held_sum got=%h exp=%h", io.out_sum, ref_sum(ba[1], bb[1], bm[1], 4));
        end
      end
      acc = io.in_valid && io.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    io.in_valid = 0;
    io.out_ready = 1;
    for (int n = 0; n < 50 && got_s.size() < 10; n++) @(negedge clk);
    @(posedge clk); #1;
    checks++; if (got_s.size() != 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", got_s.size()); end
    for (int i = 0; i < 10 && i < got_s.size(); i++) begin
      checks++; if (got_s[i] !== ref_sum(ba[i], bb[i], bm[i], 4) || got_e[i] !== ref_err(ba[i], bb[i], bm[i], 4)) begin
        failures++; $display("FAIL b2b_beat%0d got=%h/%0d exp=%h/%0d", i, got_s[i], got_e[i],
                             ref_sum(ba[i], bb[i], bm[i], 4), ref_err(ba[i], bb[i], bm[i], 4));
      end
    end
  endtask

  task automatic test_random();
    int ba[40], bb[40], bm[40];
    int idx, n_err, s_err, m_err, e;
    logic acc;
    io.stat_clr = 1;
    @(posedge clk); #1;
    io.stat_clr = 0;
    got_s.delete(); got_e.delete();
    n_err = 0; s_err = 0; m_err = 0;
    for (int i = 0; i < 40; i++) begin
      ba[i] = $urandom_range(0, 255); bb[i] = $urandom_range(0, 255); bm[i] = $urandom_range(0, 3);
      e = ref_err(ba[i], bb[i], bm[i], 4);
      n_err += (e != 0) ? 1 : 0;
      s_err += e;
      m_err = e > m_err ? e : m_err;
    end
    idx = 0;
    for (int cyc = 0; cyc < 400 && idx < 40; cyc++) begin
      io.out_ready = 1'($urandom_range(0, 1));
      io.in_valid = 1'($urandom_range(0, 3) != 0);
      io.in_a = 8'(ba[idx]); io.in_b = 8'(bb[idx]); io.in_mode = 2'(bm[idx]);
      @(negedge clk);
      acc = io.in_valid && io.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    io.in_valid = 0;
    io.out_ready = 1;
    for (int n = 0; n < 50 && got_s.size() < 40; n++) @(negedge clk);
    @(posedge clk); #1;
    checks++; if (got_s.size() != 40) begin failures++; $display("FAIL rand_count got=%0d exp=40", got_s.size()); end
    for (int i = 0; i < 40 && i < got_s.size(); i++) begin
      checks++; if (got_s[i] !== ref_sum(ba[i], bb[i], bm[i], 4) || got_e[i] !== ref_err(ba[i], bb[i], bm[i], 4)) begin
        failures++; $display("FAIL rand_beat%0d got=%h/%0d exp=%h/%0d", i, got_s[i], got_e[i],
                             ref_sum(ba[i], bb[i], bm[i], 4), ref_err(ba[i], bb[i], bm[i], 4));
      end
    end
    @(negedge clk);
    checks++; if (io.stat_samples !== 32'd40) begin failures++; $display("FAIL rand_samples got=%0d exp=40", io.stat_samples); end
    checks++; if (io.stat_err_cnt !== 32'(n_err)) begin failures++; $display("FAIL rand_err_cnt got=%0d exp=%0d", io.stat_err_cnt, n_err); end
    checks++; if (io.stat_err_sum !== 32'(s_err)) begin failures++; $display("FAIL rand_err_sum got=%0d exp=%0d", io.stat_err_sum, s_err); end
    checks++; if (io.stat_err_max !== 9'(m_err)) begin failures++; $display("FAIL rand_err_max got=%0d exp=%0d", io.stat_err_max, m_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    io.out_ready = 0;
    send('hA5, 'h5A, 0);
    send('h77, 'h11, 1);
    got_s.delete(); got_e.delete();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    io.out_ready = 1;
    @(negedge clk);
    checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", io.out_valid); end
    checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", io.in_ready); end
    checks++; if (io.stat_samples !== 32'd0 || io.stat_err_cnt !== 32'd0 || io.stat_err_sum !== 32'd0 || io.stat_err_max !== 9'd0) begin
      failures++; $display("FAIL rstmid_stats got=%0d/%0d/%0d/%0d exp=0/0/0/0", io.stat_samples, io.stat_err_cnt, io.stat_err_sum, io.stat_err_max);
    end
    repeat (5) @(negedge clk);
    checks++; if (got_s.size() != 0) begin failures++; $display("FAIL rstmid_ghost_beats got=%0d exp=0", got_s.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_k0();
    int q[$];
    int a, b, m;
    io0.out_ready = 1;
    for (int cyc = 0; cyc < 34; cyc++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255); m = $urandom_range(0, 3);
      io0.in_valid = cyc < 30;
      io0.in_a = 8'(a); io0.in_b = 8'(b); io0.in_mode = 2'(m);
      @(negedge clk);
      if (io0.out_valid) begin
        checks++; if (io0.out_err !== 9'd0) begin failures++; $display("FAIL k0_err got=%0d exp=0", io0.out_err); end
        checks++; if (q.size() == 0) begin failures++; $display("FAIL k0_unexpected_beat got=%h exp=none", io0.out_sum); end
        else if (io0.out_sum !== 9'(q.pop_front())) begin failures++; $display("FAIL k0_sum got=%h exp=exact", io0.out_sum); end
      end
      if (io0.in_valid && io0.in_ready) q.push_back(ref_sum(a, b, m, 0));
      @(posedge clk); #1;
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL k0_lost_beats got=%0d exp=0", q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_clr();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_k0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
